// File: rtl/rf_write_queue.sv
// In-order write-back queue feeding the register-file write port.
// Two producers with fixed priority (A over B), one drain per granted cycle, and combinational forwarding lookups.
module rf_write_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         a_valid_i,
   input  logic [ADDR_W-1:0]            a_adr_i,
   input  logic [DATA_W-1:0]            a_data_i,
   output logic                         a_ready_o,
   input  logic                         b_valid_i,
   input  logic [ADDR_W-1:0]            b_adr_i,
   input  logic [DATA_W-1:0]            b_data_i,
   output logic                         b_ready_o,
   input  logic                         wr_grant_i,
   output logic                         rf_wr_o,
   output logic [ADDR_W-1:0]            rf_adr_o,
   output logic [DATA_W-1:0]            rf_din_o,
   input  logic [ADDR_W-1:0]            lk_x_adr_i,
   input  logic [ADDR_W-1:0]            lk_y_adr_i,
   output logic                         fwd_x_hit_o,
   output logic [DATA_W-1:0]            fwd_x_data_o,
   output logic                         fwd_y_hit_o,
   output logic [DATA_W-1:0]            fwd_y_data_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         empty_o,
   output logic                         full_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [ADDR_W-1:0] adr_q  [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DEPTH-1:0]  vld_q;
   logic [PTR_W-1:0]  wp_q, wp_d, rp_q, rp_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              empty, full, push_a, push_b, push, pop;
   logic [ADDR_W-1:0] push_adr;
   logic [DATA_W-1:0] push_data;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(DEPTH));
   assign a_ready_o = !full;
   assign b_ready_o = !full && !a_valid_i;
   assign push_a    = a_valid_i && a_ready_o;
   assign push_b    = b_valid_i && b_ready_o;
   assign push      = push_a || push_b;
   assign pop       = !empty && wr_grant_i;
   assign push_adr  = push_a ? a_adr_i  : b_adr_i;
   assign push_data = push_a ? a_data_i : b_data_i;

   assign rf_wr_o  = pop;
   assign rf_adr_o = empty ? '0 : adr_q[rp_q];
   assign rf_din_o = empty ? '0 : data_q[rp_q];
   assign count_o  = count_q;
   assign empty_o  = empty;
   assign full_o   = full;

   always_comb begin
      wp_d    = push ? wp_q + 1'b1 : wp_q;
      rp_d    = pop  ? rp_q + 1'b1 : rp_q;
      count_d = count_q;
      if (push && !pop)
         count_d = count_q + 1'b1;
      else if (pop && !push)
         count_d = count_q - 1'b1;
   end

   // Walk oldest to youngest from RP so the last match (youngest) wins.
   always_comb begin
      fwd_x_hit_o  = 1'b0;
      fwd_x_data_o = '0;
      fwd_y_hit_o  = 1'b0;
      fwd_y_data_o = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (vld_q[rp_q + PTR_W'(i)] && adr_q[rp_q + PTR_W'(i)] == lk_x_adr_i) begin
            fwd_x_hit_o  = 1'b1;
            fwd_x_data_o = data_q[rp_q + PTR_W'(i)];
         end
         if (vld_q[rp_q + PTR_W'(i)] && adr_q[rp_q + PTR_W'(i)] == lk_y_adr_i) begin
            fwd_y_hit_o  = 1'b1;
            fwd_y_data_o = data_q[rp_q + PTR_W'(i)];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
         vld_q   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            adr_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         if (pop)
            vld_q[rp_q] <= 1'b0;
         if (push) begin
            adr_q[wp_q]  <= push_adr;
            data_q[wp_q] <= push_data;
            vld_q[wp_q]  <= 1'b1;
         end
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_rf_write_queue.sv
// Randomized and directed bench for rf_write_queue against a queue-based reference model.
module tb_rf_write_queue;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 5;

   typedef struct packed {
      logic [ADDR_W-1:0] adr;
      logic [DATA_W-1:0] data;
   } ent_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              a_valid, b_valid, grant;
   logic [ADDR_W-1:0] a_adr, b_adr, lk_x, lk_y;
   logic [DATA_W-1:0] a_data, b_data;
   logic              a_ready, b_ready, rf_wr, x_hit, y_hit, empty, full;
   logic [ADDR_W-1:0] rf_adr;
   logic [DATA_W-1:0] rf_din, x_data, y_data;
   logic [2:0]        count;

   int n_chk  = 0;
   int n_pass = 0;

   ent_t mq[$];
   ent_t exp_w[$];
   ent_t act_w[$];

   rf_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .a_valid_i(a_valid), .a_adr_i(a_adr), .a_data_i(a_data), .a_ready_o(a_ready),
      .b_valid_i(b_valid), .b_adr_i(b_adr), .b_data_i(b_data), .b_ready_o(b_ready),
      .wr_grant_i(grant),
      .rf_wr_o(rf_wr), .rf_adr_o(rf_adr), .rf_din_o(rf_din),
      .lk_x_adr_i(lk_x), .lk_y_adr_i(lk_y),
      .fwd_x_hit_o(x_hit), .fwd_x_data_o(x_data),
      .fwd_y_hit_o(y_hit), .fwd_y_data_o(y_data),
      .count_o(count), .empty_o(empty), .full_o(full)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W:0] model_fwd(input logic [ADDR_W-1:0] adr);
      for (int i = mq.size() - 1; i >= 0; i--)
         if (mq[i].adr == adr) return {1'b1, mq[i].data};
      return '0;
   endfunction

   task automatic drive(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                        input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd,
                        input logic g);
      a_valid = av; a_adr = aa; a_data = ad;
      b_valid = bv; b_adr = ba; b_data = bd;
      grant = g;
   endtask

   // Advance one clock: record observed RF write, then apply the queue rules to the model.
   task automatic tick();
      bit m_full, pa, pb, pp;
      #1;
      m_full = (mq.size() == DEPTH);
      pa = a_valid && !m_full;
      pb = b_valid && !m_full && !a_valid;
      pp = grant && (mq.size() != 0);
      if (rf_wr) act_w.push_back('{rf_adr, rf_din});
      @(posedge clk);
      if (pp) exp_w.push_back(mq.pop_front());
      if (pa) mq.push_back('{a_adr, a_data});
      else if (pb) mq.push_back('{b_adr, b_data});
      @(negedge clk);
   endtask

   task automatic drain();
      drive(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3 * DEPTH && mq.size() != 0; i++) tick();
      #1;
      n_chk++;
      if (count !== 3'd0) $display("FAIL drain_empty count=%0d required 0", count);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1, 0, 0, 1, 0, 0, 1);
      lk_x = 0; lk_y = 0;
      #3;
      n_chk++;
      if ({count, empty, full, rf_wr, rf_adr, rf_din, a_ready, b_ready, x_hit, x_data, y_hit, y_data}
          !== {3'd0, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0})
         $display("FAIL reset_outputs cnt=%0d empty=%0b full=%0b wr=%0b ardy=%0b brdy=%0b xhit=%0b required 0 1 0 0 1 0 0",
                  count, empty, full, rf_wr, a_ready, b_ready, x_hit);
      else n_pass++;
      a_valid = 0; #1;
      n_chk++;
      if (b_ready !== 1'b1) $display("FAIL reset_b_ready got %0b required 1", b_ready);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_single();
      act_w.delete(); exp_w.delete();
      drive(1, 5'd3, 8'h5A, 0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 1);
      #1;
      n_chk++;
      if ({rf_wr, rf_adr, rf_din} !== {1'b1, 5'd3, 8'h5A})
         $display("FAIL single_write wr=%0b adr=%0d din=%h required 1 3 5a", rf_wr, rf_adr, rf_din);
      else n_pass++;
      tick();
      #1;
      n_chk++;
      if (count !== 3'd0) $display("FAIL single_count got %0d required 0", count);
      else n_pass++;
   endtask

   task automatic test_fill();
      ent_t want[5];
      act_w.delete(); exp_w.delete();
      for (int i = 0; i < 4; i++) begin
         drive(1, 5'(i + 1), 8'((i + 1) * 8'h11), 0, 0, 0, 0);
         tick();
      end
      drive(1, 5'd5, 8'h55, 0, 0, 0, 0);
      #1;
      n_chk++;
      if ({full, a_ready, count} !== {1'b1, 1'b0, 3'd4})
         $display("FAIL fill_full full=%0b a_ready=%0b count=%0d required 1 0 4", full, a_ready, count);
      else n_pass++;
      tick();
      n_chk++;
      if (count !== 3'd4) $display("FAIL fill_hold count=%0d required 4", count);
      else n_pass++;
      grant = 1;
      tick();
      #1;
      n_chk++;
      if ({a_ready, count} !== {1'b1, 3'd3})
         $display("FAIL fill_after_pop a_ready=%0b count=%0d required 1 3", a_ready, count);
      else n_pass++;
      tick();
      drain();
      want = '{'{5'd1, 8'h11}, '{5'd2, 8'h22}, '{5'd3, 8'h33}, '{5'd4, 8'h44}, '{5'd5, 8'h55}};
      n_chk++;
      if (act_w.size() != 5) $display("FAIL fill_order_len got %0d required 5", act_w.size());
      else n_pass++;
      for (int i = 0; i < 5 && i < act_w.size(); i++) begin
         n_chk++;
         if (act_w[i] !== want[i])
            $display("FAIL fill_order[%0d] got adr=%0d d=%h required adr=%0d d=%h",
                     i, act_w[i].adr, act_w[i].data, want[i].adr, want[i].data);
         else n_pass++;
      end
   endtask

   task automatic test_priority();
      act_w.delete(); exp_w.delete();
      drive(1, 5'd7, 8'h01, 1, 5'd8, 8'h02, 0);
      #1;
      n_chk++;
      if ({a_ready, b_ready} !== 2'b10) $display("FAIL prio_ready a=%0b b=%0b required 1 0", a_ready, b_ready);
      else n_pass++;
      tick();
      a_valid = 0;
      #1;
      n_chk++;
      if (b_ready !== 1'b1) $display("FAIL prio_b_ready got %0b required 1", b_ready);
      else n_pass++;
      tick();
      drain();
      n_chk++;
      if (act_w.size() != 2 || act_w[0] !== ent_t'({5'd7, 8'h01}) || act_w[1] !== ent_t'({5'd8, 8'h02}))
         $display("FAIL prio_order n=%0d required adr 7 then adr 8", act_w.size());
      else n_pass++;
   endtask

   task automatic test_forward();
      act_w.delete(); exp_w.delete();
      drive(1, 5'd5, 8'h10, 0, 0, 0, 0); tick();
      drive(1, 5'd5, 8'h20, 0, 0, 0, 0); tick();
      drive(1, 5'd6, 8'h30, 0, 0, 0, 0); tick();
      drive(1, 5'd9, 8'h99, 0, 0, 0, 0);
      lk_x = 5'd5; lk_y = 5'd9;
      #1;
      n_chk++;
      if ({x_hit, x_data, y_hit, y_data} !== {1'b1, 8'h20, 1'b0, 8'h00})
         $display("FAIL fwd_basic xhit=%0b xd=%h yhit=%0b yd=%h required 1 20 0 00", x_hit, x_data, y_hit, y_data);
      else n_pass++;
      a_valid = 0; grant = 1; lk_x = 5'd6;
      #1;
      n_chk++;
      if ({x_hit, x_data} !== {1'b1, 8'h30}) $display("FAIL fwd_adr6 hit=%0b d=%h required 1 30", x_hit, x_data);
      else n_pass++;
      tick(); tick();
      lk_y = 5'd5;
      #1;
      n_chk++;
      if ({y_hit, y_data} !== {1'b0, 8'h00}) $display("FAIL fwd_after_pop hit=%0b d=%h required 0 00", y_hit, y_data);
      else n_pass++;
      drain();
   endtask

   task automatic test_simul();
      int bad = 0;
      act_w.delete(); exp_w.delete();
      drive(1, 5'd10, 8'hA0, 0, 0, 0, 0); tick();
      drive(1, 5'd11, 8'hA1, 0, 0, 0, 0); tick();
      for (int i = 0; i < 10; i++) begin
         drive(1, 5'(12 + i), 8'($urandom), 0, 0, 0, 1);
         tick();
         if (count !== 3'd2) bad++;
      end
      n_chk++;
      if (bad != 0) $display("FAIL simul_count %0d cycles off required count 2", bad);
      else n_pass++;
      drain();
      n_chk++;
      if (act_w.size() != 12 || act_w != exp_w)
         $display("FAIL simul_order got %0d writes required 12 in push order", act_w.size());
      else n_pass++;
   endtask

   task automatic test_random();
      int bad_out = 0, bad_fwd = 0;
      logic [DATA_W:0] fx, fy;
      bit m_full;
      act_w.delete(); exp_w.delete();
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 300; c++) begin
         if (!a_valid) begin a_valid = ($urandom_range(0, 2) == 0); a_adr = 5'($urandom); a_data = 8'($urandom); end
         if (!b_valid) begin b_valid = ($urandom_range(0, 2) == 0); b_adr = 5'($urandom); b_data = 8'($urandom); end
         grant = ($urandom_range(0, 1) == 1);
         lk_x = 5'($urandom_range(0, 7)); lk_y = 5'($urandom_range(0, 7));
         a_adr = (a_adr & 5'd7); b_adr = (b_adr & 5'd7);
         #1;
         m_full = (mq.size() == DEPTH);
         fx = model_fwd(lk_x); fy = model_fwd(lk_y);
         if (a_ready !== !m_full || b_ready !== (!m_full && !a_valid) ||
             rf_wr !== (grant && mq.size() != 0) || count !== 3'(mq.size()) ||
             empty !== (mq.size() == 0) || full !== m_full ||
             (mq.size() != 0 && {rf_adr, rf_din} !== mq[0]) ||
             (mq.size() == 0 && {rf_adr, rf_din} !== '0))
            bad_out++;
         if ({x_hit, x_data} !== fx || {y_hit, y_data} !== fy) bad_fwd++;
         begin
            bit acc_a = a_valid && !m_full;
            bit acc_b = b_valid && !m_full && !a_valid;
            tick();
            if (acc_a) a_valid = 0;
            if (acc_b) b_valid = 0;
         end
      end
      n_chk++;
      if (bad_out != 0) $display("FAIL rand_outputs %0d cycles differ required 0", bad_out);
      else n_pass++;
      n_chk++;
      if (bad_fwd != 0) $display("FAIL rand_forward %0d cycles differ required 0", bad_fwd);
      else n_pass++;
      drain();
      n_chk++;
      if (act_w != exp_w) $display("FAIL rand_order got %0d writes required %0d", act_w.size(), exp_w.size());
      else n_pass++;
   endtask

   task automatic test_async_reset();
      act_w.delete(); exp_w.delete();
      for (int i = 0; i < 3; i++) begin
         drive(1, 5'(20 + i), 8'(8'hC0 + i), 0, 0, 0, 0);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 1);
      #1;
      n_chk++;
      if (count !== 3'd3) $display("FAIL areset_pre count=%0d required 3", count);
      else n_pass++;
      #1 rst_n = 1'b0;
      #1;
      n_chk++;
      if ({count, empty, rf_wr} !== {3'd0, 1'b1, 1'b0})
         $display("FAIL areset_immediate count=%0d empty=%0b wr=%0b required 0 1 0", count, empty, rf_wr);
      else n_pass++;
      mq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      act_w.delete();
      for (int i = 0; i < 5; i++) tick();
      n_chk++;
      if (act_w.size() != 0 || count !== 3'd0)
         $display("FAIL areset_no_writes writes=%0d count=%0d required 0 0", act_w.size(), count);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_priority();
      test_forward();
      test_simul();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
